// File: rtl/poc_usbdev_if.sv
// Tile-side pin bundle for the USB receive front end: enable, user inputs,
// received byte and the bidirectional pin group carrying D+/D- and status.
interface poc_usbdev_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uo_out;
   logic [7:0] uio_in;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/poc_usbdev.sv
// USB 1.1 full-speed receive front end: 4x oversampled DPLL, NRZI decode,
// SYNC detect, bit unstuffing, byte assembly, PID check, EOP and bus reset.
module poc_usbdev #(
   parameter int OVERSAMPLE       = 4,
   parameter int SAMPLE_PHASE     = 2,
   parameter int BUS_RESET_CYCLES = 120
) (
   input logic         clk,
   input logic         rst_n,
   poc_usbdev_if.slave bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int RW = $clog2(BUS_RESET_CYCLES + 1);
   localparam logic [1:0] LS_J   = 2'b10;
   localparam logic [1:0] LS_K   = 2'b01;
   localparam logic [1:0] LS_SE0 = 2'b00;
   localparam logic [1:0] LS_SE1 = 2'b11;
   localparam logic [7:0] SYNC_PATTERN = 8'h80;

   typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, WAIT_IDLE} state_t;

   state_t        state, state_n;
   logic [1:0]    meta, line;
   logic [CW-1:0] dpll_cnt;
   logic [RW-1:0] se0_cnt;
   logic [1:0]    prev_jk, prev_jk_n;
   logic [7:0]    shift, shift_n;
   logic [2:0]    nbits, nbits_n;
   logic [2:0]    ones, ones_n;
   logic [2:0]    jcnt, jcnt_n;
   logic          seen_se0, seen_se0_n;
   logic          first_byte, first_byte_n;
   logic [7:0]    rx_byte, rx_byte_n;
   logic          byte_valid, byte_valid_n;
   logic          eop, eop_n;
   logic          pkt_active, pkt_active_n;
   logic          pid_ok, pid_ok_n;
   logic          rx_err, bus_reset, err_set;
   logic          sample, nrzi_bit, is_j, is_k, is_se0, is_se1, bus_rst_hit, clr;
   logic [7:0]    asm_byte;
   logic          unused_pins;

   assign unused_pins = ^{bus.ena, bus.ui_in[7:1], bus.uio_in[7:2]};
   assign clr         = bus.ui_in[0];
   assign is_j        = (line == LS_J);
   assign is_k        = (line == LS_K);
   assign is_se0      = (line == LS_SE0);
   assign is_se1      = (line == LS_SE1);
   assign sample      = (dpll_cnt == CW'(SAMPLE_PHASE));
   assign nrzi_bit    = (line == prev_jk);
   assign asm_byte    = {nrzi_bit, shift[7:1]};
   assign bus_rst_hit = is_se0 && (se0_cnt >= RW'(BUS_RESET_CYCLES - 1));

   // The DPLL restarts when the synchronizer is about to present a new line
   // state, so the count is 0 in the first cycle that state is visible.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta     <= '0;
         line     <= '0;
         dpll_cnt <= '0;
         se0_cnt  <= '0;
      end else begin
         meta <= {bus.uio_in[0], bus.uio_in[1]};
         line <= meta;
         if (meta != line || dpll_cnt == CW'(OVERSAMPLE - 1))
            dpll_cnt <= '0;
         else
            dpll_cnt <= dpll_cnt + 1'b1;
         if (!is_se0)
            se0_cnt <= '0;
         else if (se0_cnt != RW'(BUS_RESET_CYCLES))
            se0_cnt <= se0_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         prev_jk    <= LS_J;
         shift      <= '0;
         nbits      <= '0;
         ones       <= '0;
         jcnt       <= '0;
         seen_se0   <= 1'b0;
         first_byte <= 1'b0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         eop        <= 1'b0;
         pkt_active <= 1'b0;
         pid_ok     <= 1'b0;
         rx_err     <= 1'b0;
         bus_reset  <= 1'b0;
      end else begin
         state      <= state_n;
         prev_jk    <= prev_jk_n;
         shift      <= shift_n;
         nbits      <= nbits_n;
         ones       <= ones_n;
         jcnt       <= jcnt_n;
         seen_se0   <= seen_se0_n;
         first_byte <= first_byte_n;
         rx_byte    <= rx_byte_n;
         byte_valid <= byte_valid_n;
         eop        <= eop_n;
         pkt_active <= pkt_active_n;
         pid_ok     <= pid_ok_n;
         rx_err     <= err_set | (rx_err & ~clr);
         bus_reset  <= bus_rst_hit | (bus_reset & ~clr);
      end
   end

   // Receiver sequencing; every decision is taken only on a DPLL sample.
   always_comb begin
      state_n      = state;
      prev_jk_n    = prev_jk;
      shift_n      = shift;
      nbits_n      = nbits;
      ones_n       = ones;
      jcnt_n       = jcnt;
      seen_se0_n   = seen_se0;
      first_byte_n = first_byte;
      rx_byte_n    = rx_byte;
      byte_valid_n = 1'b0;
      eop_n        = 1'b0;
      pkt_active_n = pkt_active;
      pid_ok_n     = pid_ok;
      err_set      = 1'b0;
      if (sample) begin
         if (is_j || is_k) prev_jk_n = line;
         if (is_se1) begin
            err_set      = 1'b1;
            pkt_active_n = 1'b0;
            state_n      = IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (is_k) begin
                     state_n = SYNC;
                     shift_n = '0;
                     nbits_n = 3'd1;
                  end
               end
               SYNC: begin
                  if (is_se0) begin
                     state_n = IDLE;
                  end else begin
                     shift_n = asm_byte;
                     if (nbits == 3'd7) begin
                        if (asm_byte == SYNC_PATTERN) begin
                           state_n      = DATA;
                           pkt_active_n = 1'b1;
                           pid_ok_n     = 1'b0;
                           nbits_n      = '0;
                           ones_n       = '0;
                           first_byte_n = 1'b1;
                        end else begin
                           state_n = IDLE;
                        end
                     end else begin
                        nbits_n = nbits + 3'd1;
                     end
                  end
               end
               DATA: begin
                  if (is_se0) begin
                     state_n = EOP;
                  end else if (ones == 3'd6) begin
                     ones_n = '0;
                     if (nrzi_bit) begin
                        err_set      = 1'b1;
                        pkt_active_n = 1'b0;
                        state_n      = WAIT_IDLE;
                        jcnt_n       = '0;
                        seen_se0_n   = 1'b0;
                     end
                  end else begin
                     shift_n = asm_byte;
                     nbits_n = nbits + 3'd1;
                     ones_n  = nrzi_bit ? ones + 3'd1 : 3'd0;
                     if (nbits == 3'd7) begin
                        rx_byte_n    = asm_byte;
                        byte_valid_n = 1'b1;
                        first_byte_n = 1'b0;
                        if (first_byte) pid_ok_n = (asm_byte[7:4] == ~asm_byte[3:0]);
                     end
                  end
               end
               EOP: begin
                  if (is_j) begin
                     eop_n        = 1'b1;
                     pkt_active_n = 1'b0;
                     state_n      = IDLE;
                     if (nbits != 3'd0) err_set = 1'b1;
                  end else if (is_k) begin
                     err_set      = 1'b1;
                     pkt_active_n = 1'b0;
                     state_n      = WAIT_IDLE;
                     jcnt_n       = '0;
                     seen_se0_n   = 1'b0;
                  end
               end
               WAIT_IDLE: begin
                  if (is_se0) begin
                     seen_se0_n = 1'b1;
                     jcnt_n     = '0;
                  end else if (is_j) begin
                     if (seen_se0 || jcnt == 3'd7) state_n = IDLE;
                     else jcnt_n = jcnt + 3'd1;
                  end else begin
                     seen_se0_n = 1'b0;
                     jcnt_n     = '0;
                  end
               end
               default: state_n = IDLE;
            endcase
         end
      end
      // A bus reset overrides whatever the sample decided.
      if (bus_rst_hit) begin
         state_n      = IDLE;
         pkt_active_n = 1'b0;
      end
   end

   assign bus.uo_out  = rx_byte;
   assign bus.uio_out = {eop, bus_reset, rx_err, pid_ok, pkt_active, byte_valid, 2'b00};
   assign bus.uio_oe  = 8'hFC;
endmodule

// File: tb/tb_poc_usbdev.sv
// Directed bench for poc_usbdev: table of NRZI-encoded packets plus
// hand sequences for reset, SE1 and bus reset.
module tb_poc_usbdev;
   localparam logic [1:0] PIN_J   = 2'b01;
   localparam logic [1:0] PIN_K   = 2'b10;
   localparam logic [1:0] PIN_SE0 = 2'b00;
   localparam logic [1:0] PIN_SE1 = 2'b11;
   localparam int NV = 8;

   typedef struct {
      logic [7:0] b0;
      logic [7:0] b1;
      int         nbytes;
      int         extra;
      bit         bad_stuff;
      bit         jitter;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
      bit         exp_pid;
      bit         exp_err;
      int         exp_bv;
      int         exp_eop;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   bv_total = 0;
   int   eop_total = 0;
   int   ovl_total = 0;
   int   act_total = 0;
   logic [7:0] rx_log [16];
   vec_t vecs [NV];

   always #10 clk = ~clk;

   poc_usbdev_if bus();

   poc_usbdev dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Pulse and byte bookkeeping, sampled on the falling edge.
   always @(negedge clk) begin
      if (bus.uio_out[2] === 1'b1) begin
         rx_log[bv_total % 16] <= bus.uo_out;
         bv_total <= bv_total + 1;
      end
      if (bus.uio_out[7] === 1'b1) eop_total <= eop_total + 1;
      if (bus.uio_out[2] === 1'b1 && bus.uio_out[7] === 1'b1) ovl_total <= ovl_total + 1;
      if (bus.uio_out[3] === 1'b1) act_total <= act_total + 1;
   end

   function automatic vec_t mkVec(input logic [7:0] b0, input logic [7:0] b1, input int nb,
                                  input int ex, input bit bad, input bit jit,
                                  input logic [7:0] f, input logic [7:0] l, input bit pid,
                                  input bit err, input int bv, input int eo);
      vec_t v;
      v.b0 = b0; v.b1 = b1; v.nbytes = nb; v.extra = ex; v.bad_stuff = bad; v.jitter = jit;
      v.exp_first = f; v.exp_last = l; v.exp_pid = pid; v.exp_err = err;
      v.exp_bv = bv; v.exp_eop = eo;
      return v;
   endfunction

   function automatic int cellLen(input bit jit, input int idx);
      if (!jit) return 4;
      return (idx % 2 == 1) ? 5 : 3;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic realign();
      @(posedge clk);
      #1;
   endtask

   task automatic drivePins(input logic [1:0] p, input int n);
      bus.uio_in = {6'b0, p};
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clearFlags();
      bus.ui_in = 8'h01;
      @(posedge clk);
      #1;
      bus.ui_in = 8'h00;
   endtask

   // Builds SYNC + stuffed payload + optional trailing bits, NRZI-encodes it
   // starting from idle J, then sends a two-bit SE0 and J.
   task automatic applyStimulus(input vec_t v);
      bit         q[$];
      logic [1:0] lvl;
      logic [7:0] b;
      logic [2:0] extra_pat;
      int         ones;
      int         idx;
      extra_pat = 3'b101;
      for (int i = 0; i < 7; i++) q.push_back(1'b0);
      q.push_back(1'b1);
      ones = 0;
      for (int n = 0; n < v.nbytes; n++) begin
         b = (n == 0) ? v.b0 : v.b1;
         for (int i = 0; i < 8; i++) begin
            q.push_back(b[i]);
            ones = b[i] ? ones + 1 : 0;
            if (ones == 6) begin
               q.push_back(v.bad_stuff);
               ones = 0;
            end
         end
      end
      for (int i = 0; i < v.extra; i++) q.push_back(extra_pat[i]);
      lvl = PIN_J;
      idx = 0;
      foreach (q[i]) begin
         if (!q[i]) lvl = (lvl == PIN_J) ? PIN_K : PIN_J;
         drivePins(lvl, cellLen(v.jitter, idx));
         idx++;
      end
      drivePins(PIN_SE0, cellLen(v.jitter, idx));
      idx++;
      drivePins(PIN_SE0, cellLen(v.jitter, idx));
      drivePins(PIN_J, 16);
   endtask

   initial begin
      int   bv0, eop0, act0;
      logic pkt_seen;

      vecs[0] = mkVec(8'h69, 8'h00, 1, 0, 1'b0, 1'b0, 8'h69, 8'h69, 1'b1, 1'b0, 1, 1);
      vecs[1] = mkVec(8'h6A, 8'h00, 1, 0, 1'b0, 1'b0, 8'h6A, 8'h6A, 1'b0, 1'b0, 1, 1);
      vecs[2] = mkVec(8'hC3, 8'hFF, 2, 0, 1'b0, 1'b0, 8'hC3, 8'hFF, 1'b1, 1'b0, 2, 1);
      vecs[3] = mkVec(8'hC3, 8'hFF, 2, 0, 1'b1, 1'b0, 8'hC3, 8'hC3, 1'b1, 1'b1, 1, 0);
      vecs[4] = mkVec(8'h69, 8'h00, 1, 0, 1'b0, 1'b1, 8'h69, 8'h69, 1'b1, 1'b0, 1, 1);
      vecs[5] = mkVec(8'h69, 8'h00, 1, 3, 1'b0, 1'b0, 8'h69, 8'h69, 1'b1, 1'b1, 1, 1);
      vecs[6] = mkVec(8'hD2, 8'h00, 1, 0, 1'b0, 1'b0, 8'hD2, 8'hD2, 1'b1, 1'b0, 1, 1);
      vecs[7] = mkVec(8'h00, 8'h00, 1, 0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1, 1);

      rst_n      = 1'b0;
      bus.ena    = 1'b1;
      bus.ui_in  = 8'h00;
      bus.uio_in = {6'b0, PIN_J};
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_uo_out", 32'(bus.uo_out), 32'h00);
      checkOutput("rst_uio_out", 32'(bus.uio_out), 32'h00);
      checkOutput("rst_uio_oe", 32'(bus.uio_oe), 32'hFC);
      realign();
      rst_n = 1'b1;
      drivePins(PIN_J, 20);

      for (int r = 0; r < NV; r++) begin
         clearFlags();
         bv0  = bv_total;
         eop0 = eop_total;
         act0 = act_total;
         applyStimulus(vecs[r]);
         @(negedge clk);
         #1;
         pkt_seen = (act_total > act0);
         checkOutput($sformatf("r%0d_uo_out", r), 32'(bus.uo_out), 32'(vecs[r].exp_last));
         checkOutput($sformatf("r%0d_first_byte", r), 32'(rx_log[bv0 % 16]), 32'(vecs[r].exp_first));
         checkOutput($sformatf("r%0d_pid_ok", r), 32'(bus.uio_out[4]), 32'(vecs[r].exp_pid));
         checkOutput($sformatf("r%0d_rx_err", r), 32'(bus.uio_out[5]), 32'(vecs[r].exp_err));
         checkOutput($sformatf("r%0d_byte_pulses", r), 32'(bv_total - bv0), 32'(vecs[r].exp_bv));
         checkOutput($sformatf("r%0d_eop_pulses", r), 32'(eop_total - eop0), 32'(vecs[r].exp_eop));
         checkOutput($sformatf("r%0d_pkt_seen", r), 32'(pkt_seen), 32'h1);
         checkOutput($sformatf("r%0d_pkt_active_end", r), 32'(bus.uio_out[3]), 32'h0);
         realign();
      end
      checkOutput("pulse_overlap", 32'(ovl_total), 32'h0);

      clearFlags();
      drivePins(PIN_SE1, 8);
      drivePins(PIN_J, 12);
      @(negedge clk);
      checkOutput("se1_rx_err", 32'(bus.uio_out[5]), 32'h1);
      realign();
      clearFlags();
      @(negedge clk);
      checkOutput("se1_rx_err_clear", 32'(bus.uio_out[5]), 32'h0);
      realign();

      bus.uio_in = {6'b0, PIN_SE0};
      repeat (120) @(posedge clk);
      @(negedge clk);
      checkOutput("busrst_early", 32'(bus.uio_out[6]), 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("busrst_set", 32'(bus.uio_out[6]), 32'h1);
      repeat (6) @(posedge clk);
      #1;
      clearFlags();
      @(negedge clk);
      checkOutput("busrst_set_wins", 32'(bus.uio_out[6]), 32'h1);
      realign();
      drivePins(PIN_J, 20);
      @(negedge clk);
      checkOutput("busrst_sticky", 32'(bus.uio_out[6]), 32'h1);
      checkOutput("busrst_pkt_active", 32'(bus.uio_out[3]), 32'h0);
      realign();
      clearFlags();
      @(negedge clk);
      checkOutput("busrst_clear", 32'(bus.uio_out[6]), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
